// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction field layout, bubble encoding,
// fetch FSM states and a saturating-increment helper.
package processor_pkg;

  localparam int INSTR_W = 32;
  localparam int TYPE_W  = 2;
  localparam int FUNC_W  = 5;

  // Field offsets below the instruction MSB.
  localparam int TYPE_OFS = 0;
  localparam int FUNC_OFS = TYPE_W;

  localparam logic [TYPE_W-1:0] TYPE_BUBBLE = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Three saturating 32-bit event counters: fetched instructions, stall cycles, redirects.
// Latency: count visible the cycle after the event; no backpressure, counters stick at all-ones.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_fetch_i,
  input  logic        inc_stall_i,
  input  logic        inc_flush_i,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_flush_o
);
  import processor_pkg::*;

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    fetched_d = sat_inc(fetched_q, inc_fetch_i);
    stall_d   = sat_inc(stall_q, inc_stall_i);
    flush_d   = sat_inc(flush_q, inc_flush_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign perf_fetched_o   = fetched_q;
  assign perf_stall_cyc_o = stall_q;
  assign perf_flush_o     = flush_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, sync imem request, IF/ID register; FETCH_PERF_CNT_EN adds perf counters.
// Latency: address issued in cycle t lands in IF/ID at t+2; stall replays the in-flight request and
// holds everything, redirect flushes IF/ID with a single bubble.
module fetch_stage #(
  parameter int              INSTR_W  = processor_pkg::INSTR_W,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(4)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [1:0]         instruction_type,
  output logic [4:0]         func
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_flush
`endif
);
  import processor_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic               inflight_valid_q, inflight_valid_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;

  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT:  state_d = stall ? ST_BOOT : ST_RUN;
        ST_RUN:   state_d = stall ? ST_STALL : ST_RUN;
        ST_STALL: state_d = stall ? ST_STALL : ST_RUN;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  always_comb begin
    pc_d             = pc_q;
    inflight_pc_d    = inflight_pc_q;
    inflight_valid_d = inflight_valid_q;
    id_valid_d       = id_valid_q;
    id_instr_d       = id_instr_q;
    id_pc_d          = id_pc_q;
    if (branch_taken) begin
      id_valid_d       = 1'b0;
      inflight_pc_d    = branch_target;
      inflight_valid_d = 1'b1;
      pc_d             = branch_target + PC_STEP;
    end else if (!stall) begin
      id_valid_d       = inflight_valid_q;
      id_instr_d       = imem_rdata;
      id_pc_d          = inflight_pc_q;
      inflight_pc_d    = pc_q;
      inflight_valid_d = 1'b1;
      pc_d             = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_BOOT;
      pc_q             <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_valid_q <= 1'b0;
      id_valid_q       <= 1'b0;
      id_instr_q       <= '0;
      id_pc_q          <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_valid_q <= inflight_valid_d;
      id_valid_q       <= id_valid_d;
      id_instr_q       <= id_instr_d;
      id_pc_q          <= id_pc_d;
    end
  end

  // While stalled, re-issue the in-flight address so imem_rdata is still its word on release.
  assign imem_addr = branch_taken                 ? branch_target :
                     (stall && inflight_valid_q)  ? inflight_pc_q : pc_q;

  assign id_valid         = id_valid_q;
  assign id_instr         = id_instr_q;
  assign id_pc            = id_pc_q;
  assign instruction_type = id_valid_q ? id_instr_q[INSTR_W-1-TYPE_OFS -: TYPE_W] : TYPE_BUBBLE;
  assign func             = id_valid_q ? id_instr_q[INSTR_W-1-FUNC_OFS -: FUNC_W] : '0;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk              (clk),
    .rst              (rst),
    .inc_fetch_i      (!branch_taken && !stall && inflight_valid_q),
    .inc_stall_i      (stall && !branch_taken),
    .inc_flush_i      (branch_taken),
    .perf_fetched_o   (perf_fetched),
    .perf_stall_cyc_o (perf_stall_cyc),
    .perf_flush_o     (perf_flush)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequence with literal expectations, then random
// reset/stall/redirect traffic checked every cycle against a queue-based fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_rdata, id_instr, id_pc;
  logic        id_valid;
  logic [1:0]  instruction_type;
  logic [4:0]  func;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cyc, perf_flush;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .id_valid         (id_valid),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .instruction_type (instruction_type),
    .func             (func)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall_cyc   (perf_stall_cyc),
    .perf_flush       (perf_flush)
`endif
  );

  // Memory content is a cheap invertible scramble of the address so type/func bits vary.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[5:2] ^ a[31:28], a[27:0]};
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: the stream of addresses in flight, the next sequential address, and what IF/ID shows.
  bit          model_ok = 1'b0;
  logic        m_id_v;
  logic [31:0] m_id_pc, m_next;
  logic [31:0] m_fly[$];
  logic [31:0] m_fetched, m_stalls, m_flushes;
  logic [31:0] e_addr, e_word;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ok  = 1'b1;
      m_id_v    = 1'b0;
      m_id_pc   = 32'd0;
      m_next    = 32'd0;
      m_fly.delete();
      m_fetched = 0;
      m_stalls  = 0;
      m_flushes = 0;
    end else if (model_ok) begin
      if (branch_taken) begin
        m_id_v = 1'b0;
        m_fly.delete();
        m_fly.push_back(branch_target);
        m_next    = branch_target + 32'd4;
        m_flushes = sat(m_flushes);
      end else if (stall) begin
        m_stalls = sat(m_stalls);
      end else begin
        if (m_fly.size() != 0) begin
          m_id_v    = 1'b1;
          m_id_pc   = m_fly.pop_front();
          m_fetched = sat(m_fetched);
        end else begin
          m_id_v = 1'b0;
        end
        m_fly.push_back(m_next);
        m_next = m_next + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      e_addr = branch_taken ? branch_target :
               (stall && m_fly.size() != 0) ? m_fly[0] : m_next;
      chk("imem_addr", imem_addr, e_addr);
      chk("id_valid", 32'(id_valid), 32'(m_id_v));
      if (m_id_v) begin
        e_word = mem_word(m_id_pc);
        chk("id_pc", id_pc, m_id_pc);
        chk("id_instr", id_instr, e_word);
        chk("instruction_type", 32'(instruction_type), 32'(e_word[31:30]));
        chk("func", 32'(func), 32'(e_word[29:25]));
      end else begin
        chk("bubble_type", 32'(instruction_type), 32'd3);
        chk("bubble_func", 32'(func), 32'd0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall_cyc", perf_stall_cyc, m_stalls);
      chk("perf_flush", perf_flush, m_flushes);
`endif
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; imem_rdata = 32'd0;
    cyc(); cyc();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_type", 32'(instruction_type), 32'd3);
    rst = 1'b0;
    cyc(); chk("boot_valid_c1", 32'(id_valid), 32'd0);
    cyc(); chk("first_valid", 32'(id_valid), 32'd1); chk("first_pc", id_pc, 32'd0);
    cyc(); chk("seq_pc4", id_pc, 32'd4);
    cyc(); chk("seq_pc8", id_pc, 32'd8);
    stall = 1'b1;
    repeat (3) begin cyc(); chk("stall_hold_pc8", id_pc, 32'd8); end
    stall = 1'b0;
    cyc(); chk("post_stall_pc12", id_pc, 32'd12);
    cyc(); chk("post_stall_pc16", id_pc, 32'd16);
    branch_taken = 1'b1; branch_target = 32'h40;
    cyc(); branch_taken = 1'b0;
    chk("redir_bubble_valid", 32'(id_valid), 32'd0);
    chk("redir_bubble_type", 32'(instruction_type), 32'd3);
    cyc(); chk("redir_pc40", id_pc, 32'h40); chk("redir_valid", 32'(id_valid), 32'd1);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    cyc(); stall = 1'b0; branch_taken = 1'b0;
    chk("stall_redir_bubble", 32'(id_valid), 32'd0);
    cyc(); chk("stall_redir_pc80", id_pc, 32'h80);
    stall = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc(); chk("rst_in_stall_valid", 32'(id_valid), 32'd0);
    chk("rst_in_stall_addr", imem_addr, 32'd0);
    rst = 1'b0; stall = 1'b0;
    cyc(); cyc(); chk("restart_pc0", id_pc, 32'd0); chk("restart_valid", 32'(id_valid), 32'd1);
    cyc(); chk("restart_pc4", id_pc, 32'd4);
`ifdef FETCH_PERF_CNT_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (5) cyc();
    stall = 1'b1; repeat (3) cyc(); stall = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h100; cyc(); branch_taken = 1'b0;
    repeat (6) cyc();
    chk("perf_fetched_10", perf_fetched, 32'd10);
    chk("perf_stall_3", perf_stall_cyc, 32'd3);
    chk("perf_flush_1", perf_flush, 32'd1);
`endif
    // Random traffic, including redirects just below the address wrap point.
    repeat (3000) begin
      rst           = ($urandom_range(0, 63) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom_range(0, 1023) << 2);
      cyc();
    end
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    repeat (4) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
